// File: rtl/cpu_sequencer.sv
//======================================================================
// Module   : cpu_sequencer
// Purpose  : Fetch/decode/execute control FSM for the Salamander-4 core.
//            Optional macro SEQ_SINGLE_STEP_EN adds a 'step' input.
// Revision : 1.0 - initial release
//======================================================================
`default_nettype none

module cpu_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int INSTR_W  = 8,
    parameter int OPCODE_W = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic [ADDR_W-1:0]  pc_val,
    input  logic               pc_wrap,
    output logic               pc_inc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic               alu_en,
    output logic               rf_we,
    output logic               instr_done,
    output logic               busy,
    output logic               halted,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [OPCODE_W-1:0] C_OP_NOP  = '0;
    localparam logic [OPCODE_W-1:0] C_OP_HALT = '1;

    state_t               r_state;
    logic [INSTR_W-1:0]   r_ir;
    logic [OPCODE_W-1:0]  w_opcode;
    logic                 w_start;
    state_t               w_boundary_state;

    assign w_opcode = r_ir[INSTR_W-1 -: OPCODE_W];

    // Start condition out of IDLE and the state taken when an instruction completes.
    always_comb begin
        w_start          = run;
        w_boundary_state = S_IDLE;
`ifdef SEQ_SINGLE_STEP_EN
        w_start = run | step;
        if (pc_wrap) begin
            w_boundary_state = S_HALT;
        end else begin
            w_boundary_state = S_IDLE;
        end
`else
        if (pc_wrap) begin
            w_boundary_state = S_HALT;
        end else if (run) begin
            w_boundary_state = S_FETCH;
        end else begin
            w_boundary_state = S_IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        r_ir    <= mem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_opcode == C_OP_HALT) begin
                        r_state <= S_HALT;
                    end else if (w_opcode == C_OP_NOP) begin
                        r_state <= w_boundary_state;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC:  r_state <= S_WB;
                S_WB:    r_state <= w_boundary_state;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode directly from the state register so reset clears them at once.
    always_comb begin
        pc_inc     = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        alu_en     = 1'b0;
        rf_we      = 1'b0;
        instr_done = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_val;
                busy     = 1'b1;
            end
            S_DECODE: begin
                busy       = 1'b1;
                pc_inc     = (w_opcode != C_OP_HALT);
                instr_done = (w_opcode == C_OP_NOP);
            end
            S_EXEC: begin
                busy   = 1'b1;
                alu_en = 1'b1;
            end
            S_WB: begin
                busy       = 1'b1;
                rf_we      = 1'b1;
                instr_done = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign ir    = r_ir;
    assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
//======================================================================
// Module   : tb_cpu_sequencer
// Purpose  : Randomized self-checking bench for cpu_sequencer using a
//            per-instruction timeline model.
// Revision : 1.0 - initial release
//======================================================================
`default_nettype none

module tb_cpu_sequencer;

    localparam logic [2:0] C_IDLE   = 3'd0;
    localparam logic [2:0] C_FETCH  = 3'd1;
    localparam logic [2:0] C_DECODE = 3'd2;
    localparam logic [2:0] C_EXEC   = 3'd3;
    localparam logic [2:0] C_WB     = 3'd4;
    localparam logic [2:0] C_HALT   = 3'd5;

    logic       clk = 1'b0;
    logic       rstn;
    logic       run;
`ifdef SEQ_SINGLE_STEP_EN
    logic       step;
`endif
    logic [4:0] pc_val;
    logic       pc_wrap;
    logic       pc_inc;
    logic       mem_req;
    logic [4:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [7:0] ir;
    logic       alu_en;
    logic       rf_we;
    logic       instr_done;
    logic       busy;
    logic       halted;
    logic [2:0] state;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] m_ir;
    logic [4:0] m_pc;
    logic [2:0] m_phase;
    logic [7:0] instr;
    logic [3:0] op;
    int         waits;
    bit         run_end;
    bit         wrap_end;
    bit         did_frst;

    always #5 clk = ~clk;

    cpu_sequencer #(.ADDR_W(5), .INSTR_W(8), .OPCODE_W(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .run        (run),
`ifdef SEQ_SINGLE_STEP_EN
        .step       (step),
`endif
        .pc_val     (pc_val),
        .pc_wrap    (pc_wrap),
        .pc_inc     (pc_inc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir         (ir),
        .alu_en     (alu_en),
        .rf_we      (rf_we),
        .instr_done (instr_done),
        .busy       (busy),
        .halted     (halted),
        .state      (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {14'd0, state, mem_req, pc_inc, alu_en, rf_we, instr_done, busy, halted, ir};
    endfunction

    function automatic logic [31:0] expv(input logic [2:0] s, input bit req, input bit inc,
                                         input bit alu, input bit we, input bit done,
                                         input logic [7:0] eir);
        bit bsy;
        bit hlt;
        bsy = (s >= C_FETCH) && (s <= C_WB);
        hlt = (s == C_HALT);
        return {14'd0, s, req, inc, alu, we, done, bsy, hlt, eir};
    endfunction

    // State entered once an instruction has completed.
    function automatic logic [2:0] after_done(input bit r, input bit w);
        if (w) return C_HALT;
`ifdef SEQ_SINGLE_STEP_EN
        return C_IDLE;
`else
        return r ? C_FETCH : C_IDLE;
`endif
    endfunction

    task automatic noise();
        run       = 1'($urandom);
        pc_wrap   = 1'($urandom);
        mem_ack   = 1'($urandom);
        mem_rdata = 8'($urandom);
`ifdef SEQ_SINGLE_STEP_EN
        step      = 1'($urandom);
`endif
    endtask

    // Called at posedge+1 with inputs already driven for this cycle.
    task automatic cyc(input string tag, input logic [2:0] s, input bit req, input bit inc,
                       input bit alu, input bit we, input bit done);
        @(negedge clk);
        check(tag, obs(), expv(s, req, inc, alu, we, done, m_ir));
        if (req) check({tag, "_addr"}, 32'(mem_addr), 32'(m_pc));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        #1;
        check(tag, obs(), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        run = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        m_ir    = 8'h00;
        m_phase = C_IDLE;
    endtask

    task automatic run_instr(input logic [7:0] ins, input logic [4:0] pc, input int nw,
                             input bit r_end, input bit w_end);
        m_pc   = pc;
        pc_val = pc;
        for (int k = 0; k <= nw; k++) begin
            noise();
            mem_ack = (k == nw);
            if (k == nw) mem_rdata = ins;
            cyc("fetch", C_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        m_ir = ins;
        noise();
        if (ins[7:4] == 4'hF) begin
            cyc("decode_halt", C_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            m_phase = C_HALT;
        end else if (ins[7:4] == 4'h0) begin
            run     = r_end;
            pc_wrap = w_end;
            cyc("decode_nop", C_DECODE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            m_phase = after_done(r_end, w_end);
        end else begin
            cyc("decode_alu", C_DECODE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            noise();
            cyc("exec", C_EXEC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            noise();
            run     = r_end;
            pc_wrap = w_end;
            cyc("wb", C_WB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            m_phase = after_done(r_end, w_end);
        end
    endtask

    initial begin
        rstn      = 1'b0;
        run       = 1'b0;
        pc_val    = 5'd0;
        pc_wrap   = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
`ifdef SEQ_SINGLE_STEP_EN
        step      = 1'b0;
`endif
        did_frst  = 1'b0;
        m_pc      = 5'd0;
        #1;
        check("reset", obs(), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        m_ir    = 8'h00;
        m_phase = C_IDLE;

        for (int n = 0; n < 300; n++) begin
            if (m_phase == C_IDLE) begin
                for (int k = 0; k < $urandom_range(0, 2); k++) begin
                    noise();
                    run = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
                    step = 1'b0;
`endif
                    cyc("idle", C_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                end
                noise();
`ifdef SEQ_SINGLE_STEP_EN
                if ($urandom_range(0, 1) == 1) begin
                    run  = 1'b0;
                    step = 1'b1;
                end else begin
                    run  = 1'b1;
                    step = 1'b0;
                end
`else
                run = 1'b1;
`endif
                cyc("idle_start", C_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                m_phase = C_FETCH;
            end else if (m_phase == C_FETCH) begin
                if ((!did_frst && n > 20) || ($urandom_range(0, 19) == 0)) begin
                    did_frst = 1'b1;
                    noise();
                    mem_ack  = 1'b0;
                    m_pc     = 5'($urandom);
                    pc_val   = m_pc;
                    #2;
                    check("pre_rst_req", 32'(mem_req), 32'd1);
                    do_reset("fetch_rst");
                end else begin
                    if (n <= 1) begin
                        run_instr(8'h10, 5'h03, 0, 1'b1, 1'b0);
                    end else begin
                        case ($urandom_range(0, 15))
                            0, 1:       op = 4'hF;
                            2, 3, 4, 5: op = 4'h0;
                            default:    op = 4'($urandom_range(1, 14));
                        endcase
                        instr    = {op, 4'($urandom)};
                        waits    = $urandom_range(0, 3);
                        run_end  = ($urandom_range(0, 9) < 7);
                        wrap_end = ($urandom_range(0, 11) == 0);
                        run_instr(instr, 5'($urandom), waits, run_end, wrap_end);
                    end
                end
            end else begin
                for (int k = 0; k < 20; k++) begin
                    noise();
                    if (k < 10) run = 1'b1;
                    cyc("halt", C_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                end
                #2;
                do_reset("halt_rst");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
